baud_gen_frac: RTL and testbench
================================

Name: baud_gen_frac

Overview:
Runtime-programmable fractional-N baud tick generator for the UART receiver and transmitter.
- Produces an oversample tick (s_tick) and a bit tick (b_tick, every OSR oversample ticks).
- Divisor has an integer part and a fractional part, so odd baud rates hit the target average frequency without a special reference clock.
- Divisor changes are glitch-free: a new divisor is staged in a shadow register and applied only at an oversample-period boundary.

Parameters:
IW, 16, width of the integer divisor and of the period counter
FW, 4, fraction bits of the divisor (resolution 1/2^FW clock)
OSR, 16, oversample ticks per bit tick (legal range >= 2)
OW, 4, width of os_cnt (ceil(log2(OSR)))
DEF_INT, 27, integer divisor loaded at reset (50 MHz, 115200 baud, x16)
DEF_FRAC, 2, fractional divisor loaded at reset (27.125 average)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; 0 freezes all state
restart  input  1  synchronous restart of phase, accumulator and os_cnt
div_int  input  IW  new integer divisor
div_frac  input  FW  new fractional divisor
div_load  input  1  one-cycle strobe that captures div_int/div_frac into the shadow register
div_pending  output  1  high while a captured divisor is not yet applied
s_tick  output  1  oversample tick, one cycle wide
b_tick  output  1  bit tick, one cycle wide, coincident with an s_tick
q  output  IW  current period counter value
os_cnt  output  OW  oversample index within the current bit, 0..OSR-1

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - Active divisor := DEF_INT/DEF_FRAC; shadow := same.
  - q=0, acc=0, carry c=0, os_cnt=0, div_pending=0, s_tick=0, b_tick=0.
- Effective integer divisor D = max(active_int, 2). Values 0 and 1 are clamped to 2.
- Period length: L = D + c cycles, where c is the carry stored at the end of the previous period. The first period after reset or restart has c=0.
- Counter: q counts 0..L-1 while en=1. Period end is the cycle where q == L-1. Compare in IW+1 bits so that D = 2^IW-1 with c=1 works.
- s_tick: combinational, equal to en & (q == L-1). It is high during the last cycle of each period.
- At each period end (en=1):
  - q <= 0
  - {c, acc} <= acc + active_frac, an FW+1-bit sum
  - os_cnt <= (os_cnt == OSR-1) ? 0 : os_cnt + 1
- Result: the average period is D + active_frac/2^FW cycles. The carry pattern is deterministic, e.g. frac = 2^(FW-1) alternates L = D, D+1, D, D+1, ...
- b_tick = s_tick & (os_cnt == OSR-1).
- en=0: q, acc, c and os_cnt hold their values; s_tick=b_tick=0; divisor still loads into the shadow register.
- div_load:
  - Shadow <= inputs on the strobe cycle; div_pending=1 from the next cycle.
  - The shadow copies to the active divisor at the next period end (the cycle s_tick=1). The new D is used from the period that starts after it. div_pending clears on the cycle after the copy.
  - A div_load on the same cycle as a period end captures into the shadow only. It is applied at the following period end.
  - Repeated div_load strobes while pending overwrite the shadow; the last one wins.
  - acc and c are not cleared on a divisor change.
- restart (higher priority than en and the period-end update):
  - q, acc, c and os_cnt are cleared.
  - Any pending shadow is applied immediately; div_pending <= 0.
  - s_tick is forced to 0 on the restart cycle.
  - If div_load and restart occur together, the inputs go straight to the active divisor.
- Reset mid-operation: all state returns to reset values asynchronously; the first tick occurs DEF_INT cycles after reset deassertion.
- No other outputs register-delay: q, os_cnt and div_pending are registers; s_tick and b_tick are combinational decodes of them.

Test Plan:
- Reset, en=1, defaults with div_frac=0 loaded via restart (div_int=27) -> s_tick every 27 cycles, first tick on cycle 27 after restart, q sequence 0..26.
- div_int=10, div_frac=8 (FW=4), restart -> period lengths 10,11,10,11...; over 32 periods exactly 336 cycles.
- Defaults (27.125), en=1 for 16*8 periods -> b_tick every 16th s_tick, os_cnt wraps 15->0; 8 bit times = 3472 cycles total.
- div_load (div_int=5) at q=3 of a 27-cycle period -> div_pending=1, current period stays 27 cycles, next period 5 cycles, div_pending drops after the copy.
- div_int=0 and div_int=1 loaded -> period 2 cycles; en deasserted for 7 cycles at q=1 -> q frozen, no ticks, resumes at q=1.
- Assert reset at q=13 with os_cnt=9 -> all outputs 0 immediately. Assert restart with a pending divisor -> q=0, os_cnt=0, new divisor active, div_pending=0 next cycle.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: oversample tick every D + frac/2^FW clocks on average,
// bit tick every OSR oversample ticks, with a shadowed divisor applied only at period boundaries.
module baud_gen_frac #(
   parameter int IW       = 16,
   parameter int FW       = 4,
   parameter int OSR      = 16,
   parameter int OW       = 4,
   parameter int DEF_INT  = 27,
   parameter int DEF_FRAC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          restart,
   input  logic [IW-1:0] div_int,
   input  logic [FW-1:0] div_frac,
   input  logic          div_load,
   output logic          div_pending,
   output logic          s_tick,
   output logic          b_tick,
   output logic [IW-1:0] q,
   output logic [OW-1:0] os_cnt
);

   localparam logic [IW-1:0] RST_INT  = IW'(DEF_INT);
   localparam logic [FW-1:0] RST_FRAC = FW'(DEF_FRAC);
   localparam logic [OW-1:0] OS_LAST  = OW'(OSR - 1);

   logic [IW-1:0] act_int;
   logic [IW-1:0] sh_int;
   logic [FW-1:0] act_frac;
   logic [FW-1:0] sh_frac;
   logic [FW-1:0] acc;
   logic          carry;
   logic [IW:0]   d_eff;
   logic [IW:0]   last_q;
   logic          period_end;
   logic [FW:0]   acc_sum;

   // One extra bit so that D = 2^IW-1 plus a carry still compares correctly.
   always_comb begin
      d_eff      = (act_int < IW'(2)) ? (IW+1)'(2) : {1'b0, act_int};
      last_q     = d_eff + {{IW{1'b0}}, carry} - (IW+1)'(1);
      period_end = ({1'b0, q} == last_q);
      acc_sum    = {1'b0, acc} + {1'b0, act_frac};
   end

   assign s_tick = en & ~restart & period_end;
   assign b_tick = s_tick & (os_cnt == OS_LAST);

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q      <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         os_cnt <= '0;
      end else if (restart) begin
         q      <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         os_cnt <= '0;
      end else if (en) begin
         if (period_end) begin
            q              <= '0;
            {carry, acc}   <= acc_sum;
            os_cnt         <= (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
         end else begin
            q <= q + IW'(1);
         end
      end
   end

   // Shadow equals active whenever nothing is pending, so restart can always copy it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_int     <= RST_INT;
         act_frac    <= RST_FRAC;
         sh_int      <= RST_INT;
         sh_frac     <= RST_FRAC;
         div_pending <= 1'b0;
      end else if (restart) begin
         if (div_load) begin
            act_int  <= div_int;
            act_frac <= div_frac;
            sh_int   <= div_int;
            sh_frac  <= div_frac;
         end else begin
            act_int  <= sh_int;
            act_frac <= sh_frac;
         end
         div_pending <= 1'b0;
      end else begin
         if (div_load) begin
            sh_int  <= div_int;
            sh_frac <= div_frac;
         end
         if (s_tick && div_pending) begin
            act_int  <= sh_int;
            act_frac <= sh_frac;
         end
         if (div_load) begin
            div_pending <= 1'b1;
         end else if (s_tick) begin
            div_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: period lengths, fractional carry pattern, bit ticks,
// divisor shadowing, clamping, enable freeze, reset and restart.
module tb_baud_gen_frac;

   localparam int IW = 16;
   localparam int FW = 4;
   localparam int OW = 4;
   localparam int BOUND = 200;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          restart;
   logic [IW-1:0] div_int;
   logic [FW-1:0] div_frac;
   logic          div_load;
   logic          div_pending;
   logic          s_tick;
   logic          b_tick;
   logic [IW-1:0] q;
   logic [OW-1:0] os_cnt;

   int errors = 0;
   int checks = 0;

   baud_gen_frac #(
      .IW(IW), .FW(FW), .OSR(16), .OW(OW), .DEF_INT(27), .DEF_FRAC(2)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .restart(restart),
      .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
      .div_pending(div_pending), .s_tick(s_tick), .b_tick(b_tick),
      .q(q), .os_cnt(os_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Inputs change and outputs are sampled 1 ns after the falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Cycles from the current cycle up to and including the next s_tick cycle; leaves the bench one cycle past it.
   task automatic wait_tick(output int n);
      n = 1;
      while (s_tick !== 1'b1 && n < BOUND) begin
         tick();
         n++;
      end
      tick();
   endtask

   task automatic do_restart(input int di, input int df);
      div_int  = IW'(di);
      div_frac = FW'(df);
      div_load = 1'b1;
      restart  = 1'b1;
      tick();
      div_load = 1'b0;
      restart  = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      #2;
      checks++;
      if (q !== '0 || os_cnt !== '0 || div_pending !== 1'b0 || s_tick !== 1'b0 || b_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: q=%0d os_cnt=%0d pend=%b s=%b b=%b, required all zero",
                  q, os_cnt, div_pending, s_tick, b_tick);
      end
      tick();
      reset = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 27) begin
         errors++;
         $display("FAIL reset_first_period: got %0d cycles, required 27", n);
      end
   endtask

   task automatic test_int_div();
      int n;
      int bad = 0;
      do_restart(27, 0);
      for (int i = 0; i < 27; i++) begin
         if (q !== IW'(i) || s_tick !== (i == 26)) begin
            bad++;
            $display("FAIL int_q_seq: step %0d q=%0d s_tick=%b, required q=%0d s_tick=%b",
                     i, q, s_tick, i, (i == 26));
         end
         tick();
      end
      checks++;
      if (bad != 0) errors++;
      for (int k = 0; k < 3; k++) begin
         wait_tick(n);
         checks++;
         if (n !== 27) begin
            errors++;
            $display("FAIL int_period: period %0d got %0d cycles, required 27", k, n);
         end
      end
   endtask

   task automatic test_frac_div();
      int n;
      int total = 0;
      do_restart(10, 8);
      wait_tick(n);
      checks++;
      if (n !== 10) begin
         errors++;
         $display("FAIL frac_first_period: got %0d, required 10", n);
      end
      for (int k = 2; k <= 33; k++) begin
         wait_tick(n);
         total += n;
         checks++;
         if (n !== ((k % 2 == 1) ? 11 : 10)) begin
            errors++;
            $display("FAIL frac_period: period %0d got %0d, required %0d", k, n, (k % 2 == 1) ? 11 : 10);
         end
      end
      checks++;
      if (total !== 336) begin
         errors++;
         $display("FAIL frac_total_32: got %0d cycles, required 336", total);
      end
   endtask

   task automatic test_bit_tick();
      int cyc = 1;
      int snum = 0;
      int first = 0;
      int last = 0;
      int bcount = 0;
      int mism = 0;
      do_restart(27, 2);
      while (snum < 129 && cyc < 6000) begin
         if (s_tick === 1'b1) begin
            if (b_tick !== ((snum % 16) == 15) || os_cnt !== OW'(snum % 16)) mism++;
            if (b_tick === 1'b1) bcount++;
            if (snum == 0) first = cyc;
            if (snum == 128) last = cyc;
            snum++;
         end else if (b_tick !== 1'b0) begin
            mism++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (first !== 27) begin
         errors++;
         $display("FAIL bit_first_tick: got cycle %0d, required 27", first);
      end
      checks++;
      if (last - first !== 3472) begin
         errors++;
         $display("FAIL bit_8_bits: got %0d cycles, required 3472", last - first);
      end
      checks++;
      if (bcount !== 8) begin
         errors++;
         $display("FAIL bit_count: got %0d b_ticks, required 8", bcount);
      end
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("FAIL bit_os_cnt: got %0d b_tick/os_cnt mismatches, required 0", mism);
      end
   endtask

   task automatic test_div_load();
      int n;
      do_restart(27, 0);
      repeat (3) tick();
      checks++;
      if (q !== IW'(3)) begin
         errors++;
         $display("FAIL load_setup_q: got %0d, required 3", q);
      end
      div_int  = IW'(5);
      div_frac = '0;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      checks++;
      if (div_pending !== 1'b1) begin
         errors++;
         $display("FAIL load_pending_set: got %b, required 1", div_pending);
      end
      wait_tick(n);
      checks++;
      if (n !== 23) begin
         errors++;
         $display("FAIL load_current_period: got %0d remaining, required 23", n);
      end
      checks++;
      if (div_pending !== 1'b0) begin
         errors++;
         $display("FAIL load_pending_clear: got %b, required 0", div_pending);
      end
      for (int k = 0; k < 2; k++) begin
         wait_tick(n);
         checks++;
         if (n !== 5) begin
            errors++;
            $display("FAIL load_new_period: got %0d, required 5", n);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      repeat (4) tick();
      checks++;
      if (s_tick !== 1'b1) begin
         errors++;
         $display("FAIL b2b_setup_tick: got %b, required 1", s_tick);
      end
      div_int  = IW'(7);
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      checks++;
      if (div_pending !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pending: got %b, required 1", div_pending);
      end
      wait_tick(n);
      checks++;
      if (n !== 5 || div_pending !== 1'b0) begin
         errors++;
         $display("FAIL b2b_deferred: got %0d cycles pend=%b, required 5 pend=0", n, div_pending);
      end
      wait_tick(n);
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL b2b_applied: got %0d, required 7", n);
      end
      div_int  = IW'(9);
      div_load = 1'b1;
      tick();
      div_int  = IW'(4);
      tick();
      div_load = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL b2b_overwrite_cur: got %0d, required 5", n);
      end
      wait_tick(n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL b2b_last_wins: got %0d, required 4", n);
      end
      repeat (3) tick();
      restart = 1'b1;
      #1;
      checks++;
      if (s_tick !== 1'b0 || b_tick !== 1'b0) begin
         errors++;
         $display("FAIL restart_masks_tick: s=%b b=%b, required 0 0", s_tick, b_tick);
      end
      tick();
      restart = 1'b0;
      checks++;
      if (q !== '0) begin
         errors++;
         $display("FAIL restart_q: got %0d, required 0", q);
      end
   endtask

   task automatic test_clamp_en();
      int n;
      int bad = 0;
      logic [OW-1:0] os_hold;
      do_restart(0, 0);
      for (int k = 0; k < 2; k++) begin
         wait_tick(n);
         checks++;
         if (n !== 2) begin
            errors++;
            $display("FAIL clamp_zero: got %0d, required 2", n);
         end
      end
      do_restart(1, 0);
      wait_tick(n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL clamp_one: got %0d, required 2", n);
      end
      tick();
      os_hold = os_cnt;
      en = 1'b0;
      #1;
      for (int i = 0; i < 7; i++) begin
         if (q !== IW'(1) || s_tick !== 1'b0 || b_tick !== 1'b0 || os_cnt !== os_hold) begin
            bad++;
            $display("FAIL en_freeze: cycle %0d q=%0d s=%b os=%0d, required q=1 s=0 os=%0d",
                     i, q, s_tick, os_cnt, os_hold);
         end
         tick();
      end
      checks++;
      if (bad != 0) errors++;
      en = 1'b1;
      #1;
      checks++;
      if (q !== IW'(1) || s_tick !== 1'b1) begin
         errors++;
         $display("FAIL en_resume: q=%0d s=%b, required q=1 s=1", q, s_tick);
      end
      tick();
      checks++;
      if (q !== '0) begin
         errors++;
         $display("FAIL en_resume_wrap: got q=%0d, required 0", q);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int total = 0;
      do_restart(27, 0);
      repeat (9) begin
         wait_tick(n);
         total += n;
      end
      repeat (13) tick();
      checks++;
      if (total !== 243 || q !== IW'(13) || os_cnt !== OW'(9)) begin
         errors++;
         $display("FAIL mid_setup: total=%0d q=%0d os=%0d, required 243 13 9", total, q, os_cnt);
      end
      div_int  = IW'(6);
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (q !== '0 || os_cnt !== '0 || div_pending !== 1'b0 || s_tick !== 1'b0 || b_tick !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async: q=%0d os=%0d pend=%b s=%b b=%b, required all zero",
                  q, os_cnt, div_pending, s_tick, b_tick);
      end
      tick();
      reset = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 27) begin
         errors++;
         $display("FAIL mid_reset_first_tick: got %0d, required 27", n);
      end
      repeat (3) tick();
      div_int  = IW'(6);
      div_frac = '0;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      div_int  = IW'(99);
      checks++;
      if (div_pending !== 1'b1) begin
         errors++;
         $display("FAIL restart_setup_pend: got %b, required 1", div_pending);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (q !== '0 || os_cnt !== '0 || div_pending !== 1'b0) begin
         errors++;
         $display("FAIL restart_pending: q=%0d os=%0d pend=%b, required 0 0 0", q, os_cnt, div_pending);
      end
      wait_tick(n);
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL restart_applies_shadow: got %0d, required 6", n);
      end
   endtask

   initial begin
      reset    = 1'b1;
      en       = 1'b1;
      restart  = 1'b0;
      div_load = 1'b0;
      div_int  = '0;
      div_frac = '0;
      test_reset();
      test_int_div();
      test_frac_div();
      test_bit_tick();
      test_div_load();
      test_back_to_back();
      test_clamp_en();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
